hilo_muldiv_unit: RTL and testbench

HILO_MULDIV_UNIT -- requirements
Module: hilo_muldiv_unit

---
 rtl/hilo_muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_hilo_muldiv_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative radix-2 multiply/divide unit with architectural HI/LO registers.
//
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   start, op       - request and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   src_a, src_b    - operands (src_a is also MTHI/MTLO data)
//   cancel          - abort an in-flight mul/div
//   ready, busy     - ready == !busy; busy while a mul/div iterates
//   done            - one-cycle pulse after a mul/div result lands in HI/LO
//   hi_out, lo_out  - registered HI/LO contents
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             cancel,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int CntW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpMult = 3'd0;
    localparam logic [2:0] OpDiv  = 3'd2;
    localparam logic [2:0] OpMthi = 3'd4;
    localparam logic [2:0] OpMtlo = 3'd5;

    typedef enum logic [0:0] {StIdle, StRun} stateE;

    stateE             stateQ, stateD;
    logic [CntW-1:0]   cntQ, cntD;
    logic [WIDTH-1:0]  accHiQ, accHiD;
    logic [WIDTH-1:0]  accLoQ, accLoD;
    logic [WIDTH-1:0]  opndQ, opndD;     // multiplicand or divisor magnitude
    logic              isDivQ, isDivD;
    logic              negResQ, negResD; // negate product / quotient at commit
    logic              negRemQ, negRemD; // remainder takes the dividend's sign
    logic              divZeroQ, divZeroD;
    logic [WIDTH-1:0]  hiQ, hiD;
    logic [WIDTH-1:0]  loQ, loD;
    logic              doneQ, doneD;

    // Operand magnitudes for the request being presented
    logic              signedOp, negA, negB;
    logic [WIDTH-1:0]  magA, magB;

    assign signedOp = (op == OpMult) || (op == OpDiv);
    assign negA     = signedOp && src_a[WIDTH-1];
    assign negB     = signedOp && src_b[WIDTH-1];
    assign magA     = negA ? -src_a : src_a;
    assign magB     = negB ? -src_b : src_b;

    // One radix-2 step, both flavours
    logic [WIDTH:0]    addend, addSum;
    logic [WIDTH:0]    shifted;
    logic [WIDTH-1:0]  diffLow;
    logic              fits;
    logic [WIDTH-1:0]  iterHi, iterLo;

    always_comb begin
        addend  = accLoQ[0] ? {1'b0, opndQ} : {(WIDTH + 1){1'b0}};
        addSum  = {1'b0, accHiQ} + addend;
        shifted = {accHiQ, accLoQ[WIDTH-1]};
        fits    = shifted >= {1'b0, opndQ};
        // Only used when fits, where the true difference is below 2^WIDTH
        diffLow = shifted[WIDTH-1:0] - opndQ;
        if (isDivQ) begin
            iterHi = fits ? diffLow : shifted[WIDTH-1:0];
            iterLo = {accLoQ[WIDTH-2:0], fits};
        end else begin
            iterHi = addSum[WIDTH:1];
            iterLo = {addSum[0], accLoQ[WIDTH-1:1]};
        end
    end

    // Sign correction applied to the final iteration's result
    logic [2*WIDTH-1:0] prodMag, prodFin;
    logic [WIDTH-1:0]   quotFin, remFin;

    always_comb begin
        prodMag = {iterHi, iterLo};
        prodFin = negResQ ? -prodMag : prodMag;
        quotFin = divZeroQ ? {WIDTH{1'b1}} : (negResQ ? -iterLo : iterLo);
        remFin  = negRemQ ? -iterHi : iterHi;
    end

    always_comb begin
        stateD   = stateQ;
        cntD     = cntQ;
        accHiD   = accHiQ;
        accLoD   = accLoQ;
        opndD    = opndQ;
        isDivD   = isDivQ;
        negResD  = negResQ;
        negRemD  = negRemQ;
        divZeroD = divZeroQ;
        hiD      = hiQ;
        loD      = loQ;
        doneD    = 1'b0;
        case (stateQ)
            StIdle: begin
                if (start) begin
                    if (!op[2]) begin
                        stateD   = StRun;
                        cntD     = CntW'(WIDTH);
                        isDivD   = op[1];
                        negResD  = negA ^ negB;
                        negRemD  = negA;
                        divZeroD = op[1] && (src_b == '0);
                        accHiD   = '0;
                        // Multiply shifts the multiplier out of LO; divide shifts the dividend
                        accLoD   = op[1] ? magA : magB;
                        opndD    = op[1] ? magB : magA;
                    end else if (op == OpMthi) begin
                        hiD = src_a;
                    end else if (op == OpMtlo) begin
                        loD = src_a;
                    end
                end
            end
            StRun: begin
                if (cancel) begin
                    stateD = StIdle;
                    cntD   = '0;
                end else if (cntQ == CntW'(1)) begin
                    stateD = StIdle;
                    cntD   = '0;
                    doneD  = 1'b1;
                    if (isDivQ) begin
                        hiD = remFin;
                        loD = quotFin;
                    end else begin
                        hiD = prodFin[2*WIDTH-1:WIDTH];
                        loD = prodFin[WIDTH-1:0];
                    end
                end else begin
                    cntD   = cntQ - CntW'(1);
                    accHiD = iterHi;
                    accLoD = iterLo;
                end
            end
            default: stateD = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stateQ   <= StIdle;
            cntQ     <= '0;
            accHiQ   <= '0;
            accLoQ   <= '0;
            opndQ    <= '0;
            isDivQ   <= 1'b0;
            negResQ  <= 1'b0;
            negRemQ  <= 1'b0;
            divZeroQ <= 1'b0;
            hiQ      <= '0;
            loQ      <= '0;
            doneQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            cntQ     <= cntD;
            accHiQ   <= accHiD;
            accLoQ   <= accLoD;
            opndQ    <= opndD;
            isDivQ   <= isDivD;
            negResQ  <= negResD;
            negRemQ  <= negRemD;
            divZeroQ <= divZeroD;
            hiQ      <= hiD;
            loQ      <= loD;
            doneQ    <= doneD;
        end
    end

    assign busy   = (stateQ == StRun);
    assign ready  = ~busy;
    assign done   = doneQ;
    assign hi_out = hiQ;
    assign lo_out = loQ;

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit at WIDTH=32.
module tb_hilo_muldiv_unit;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_NOP   = 3'd6;

    logic        clk = 1'b0;
    logic        reset, start, cancel;
    logic [2:0]  op;
    logic [31:0] src_a, src_b;
    logic        ready, busy, done;
    logic [31:0] hi_out, lo_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] expHi, expLo;

    hilo_muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .cancel (cancel),
        .ready  (ready),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic moveTo(input string tag, input logic [2:0] o, input logic [31:0] a);
        start = 1'b1; op = o; src_a = a;
        tick();
        start = 1'b0;
        if (o == OP_MTHI) expHi = a;
        if (o == OP_MTLO) expLo = a;
        check({tag, " hi"}, hi_out, expHi);
        check({tag, " lo"}, lo_out, expLo);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd0);
    endtask

    // Issue a mul/div, follow it to commit; ends in the done cycle.
    task automatic runOp(input string tag, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eHi, input logic [31:0] eLo,
                         input int injectAt, input bit cancelAtAccept);
        int  n;
        bit  holdOk;
        bit  earlyDone;
        start = 1'b1; op = o; src_a = a; src_b = b; cancel = cancelAtAccept;
        tick();
        start = 1'b0; cancel = 1'b0;
        check({tag, " accept busy"}, {31'd0, busy}, 32'd1);
        check({tag, " accept ready"}, {31'd0, ready}, 32'd0);
        n = 0; holdOk = 1'b1; earlyDone = 1'b0;
        while (busy && n < 100) begin
            if (hi_out !== expHi || lo_out !== expLo) holdOk = 1'b0;
            if (done) earlyDone = 1'b1;
            n++;
            if (n == injectAt) begin
                start = 1'b1; op = OP_MTHI; src_a = 32'hDEADBEEF;
            end
            tick();
            start = 1'b0;
        end
        check({tag, " busy cycles"}, n, 32);
        check({tag, " hold"}, {31'd0, holdOk}, 32'd1);
        check({tag, " no early done"}, {31'd0, earlyDone}, 32'd0);
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " ready"}, {31'd0, ready}, 32'd1);
        check({tag, " hi"}, hi_out, eHi);
        check({tag, " lo"}, lo_out, eLo);
        expHi = eHi;
        expLo = eLo;
    endtask

    initial begin
        bit sawDone;
        reset = 1'b1; start = 1'b0; cancel = 1'b0; op = OP_NOP; src_a = '0; src_b = '0;
        expHi = '0; expLo = '0;
        tick();
        // Reset overrides a simultaneous MTHI
        start = 1'b1; op = OP_MTHI; src_a = 32'hFFFF_FFFF; cancel = 1'b1;
        tick();
        start = 1'b0; cancel = 1'b0;
        check("reset hi", hi_out, 32'h0);
        check("reset lo", lo_out, 32'h0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset ready", {31'd0, ready}, 32'd1);
        check("reset done", {31'd0, done}, 32'd0);
        reset = 1'b0;
        tick();

        moveTo("mthi", OP_MTHI, 32'h12345678);
        moveTo("mtlo", OP_MTLO, 32'h9ABCDEF0);
        moveTo("nop", OP_NOP, 32'h55555555);

        // MTHI injected during busy cycle 3 must be ignored
        runOp("mult", OP_MULT, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFE, 3, 1'b0);
        // Accepted in the done cycle
        runOp("multu", OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 0, 1'b0);
        tick();
        check("done pulse width", {31'd0, done}, 32'd0);
        runOp("div neg", OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 1'b0);
        runOp("divu by0", OP_DIVU, 32'd5, 32'd0, 32'h00000005, 32'hFFFFFFFF, 0, 1'b0);
        runOp("div ovf", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 0, 1'b0);
        runOp("div negb", OP_DIV, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0, 1'b0);
        runOp("div by0 s", OP_DIV, 32'hFFFFFFF7, 32'd0, 32'hFFFFFFF7, 32'hFFFFFFFF, 0, 1'b0);
        runOp("multu big", OP_MULTU, 32'h00010000, 32'h00010000, 32'h1, 32'h0, 0, 1'b0);
        runOp("mult minsq", OP_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 0, 1'b0);
        runOp("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b0);
        runOp("mult mix", OP_MULT, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 0, 1'b0);
        tick();

        // Cancel in busy cycle 10 of a DIVU
        start = 1'b1; op = OP_DIVU; src_a = 32'd100; src_b = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        check("cancel pre busy", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("cancel busy", {31'd0, busy}, 32'd0);
        check("cancel done", {31'd0, done}, 32'd0);
        check("cancel hi", hi_out, expHi);
        check("cancel lo", lo_out, expLo);
        runOp("post cancel", OP_MULTU, 32'd6, 32'd7, 32'd0, 32'd42, 0, 1'b0);
        tick();

        // Cancel on the commit edge suppresses the commit
        start = 1'b1; op = OP_MULTU; src_a = 32'd3; src_b = 32'd4;
        tick();
        start = 1'b0;
        for (int i = 1; i < 32; i++) tick();
        check("late cancel pre busy", {31'd0, busy}, 32'd1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("late cancel busy", {31'd0, busy}, 32'd0);
        check("late cancel done", {31'd0, done}, 32'd0);
        check("late cancel hi", hi_out, expHi);
        check("late cancel lo", lo_out, expLo);
        tick();
        check("late cancel done2", {31'd0, done}, 32'd0);

        // Cancel alone in idle does nothing; with start it still accepts
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        check("idle cancel busy", {31'd0, busy}, 32'd0);
        check("idle cancel done", {31'd0, done}, 32'd0);
        check("idle cancel lo", lo_out, expLo);
        runOp("cancel+start", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 0, 1'b1);
        tick();

        // Reset mid-MULT
        start = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expHi = '0; expLo = '0;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset hi", hi_out, 32'h0);
        check("midreset lo", lo_out, 32'h0);
        sawDone = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) sawDone = 1'b1;
            tick();
        end
        check("midreset never done", {31'd0, sawDone}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
